cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares one blocking cache (single outstanding request, 32-bit word interface) between two requesters: port 0 = instruction fetch, port 1 = data memory stage.
- Sits between the pipelined CPU and the cache. Latches one request, issues it, holds the cache inputs stable until the cache responds, then returns the response to the owning port.
- Keeps per-port service and hit counters, and a watchdog that flags a hung cache.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin between ports; 1 = port 1 always wins a tie.
- TIMEOUT_CYCLES, 1024: WAIT-state cycle limit before the sticky timeout flag is set.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 request; held high by requester until p0_resp_valid
- p0_addr  input  32  port 0 byte address
- p0_rw  input  1  port 0: 0 = read, 1 = write
- p0_din  input  32  port 0 write data
- p0_resp_valid  output  1  one-cycle pulse, port 0 response
- p0_dout  output  32  port 0 read data, valid with p0_resp_valid
- p0_hit  output  1  port 0 cache hit indication, valid with p0_resp_valid
- p1_req, p1_addr, p1_rw, p1_din, p1_resp_valid, p1_dout, p1_hit: same as port 0, for port 1
- c_is_input_valid  output  1  request strobe to the cache
- c_addr  output  32  cache address
- c_mem_rw  output  1  cache read/write select
- c_din  output  32  cache write data
- c_is_ready  input  1  cache can accept a request
- c_is_output_valid  input  1  cache output valid
- c_dout  input  32  cache read data
- c_is_hit  input  1  cache hit flag
- p0_served, p1_served  output  32  completed transactions per port
- p0_hits, p1_hits  output  32  completed transactions that were hits
- timeout_err  output  1  sticky watchdog flag

Behaviour:
- State machine: IDLE, ISSUE, WAIT, RESP. The state, owner, latched addr/rw/din and response registers are all registered.
- Reset values:
  - state = IDLE, owner = 0, last_grant = 1 (so port 0 wins the first round-robin tie).
  - All resp_valid = 0, dout = 0, hit = 0.
  - c_is_input_valid = 0, c_addr/c_mem_rw/c_din = 0.
  - All counters = 0, timeout_err = 0, wait counter = 0.
- IDLE:
  - If any req is high, select the owner, latch that port's addr/rw/din, go to ISSUE.
  - Round-robin tie: grant the port that is not last_grant, and set last_grant = owner.
  - FIXED_PRIORITY = 1 tie: grant port 1.
  - A single requester is granted regardless of policy.
- ISSUE:
  - Drive c_is_input_valid = 1 with the latched values.
  - If c_is_ready = 1, go to WAIT; otherwise stay in ISSUE.
- WAIT:
  - c_is_input_valid = 0. c_addr/c_mem_rw/c_din stay at the latched values (the cache samples addr combinationally through its miss and refill states).
  - On the first cycle with c_is_output_valid = 1: capture c_dout and c_is_hit, go to RESP.
- RESP:
  - Owner's resp_valid = 1 for exactly this cycle, with the captured dout and hit. The other port's resp_valid = 0.
  - Increment the owner's served counter; increment its hits counter if hit = 1.
  - Go to IDLE.
- c_addr/c_mem_rw/c_din hold their latched values in RESP and IDLE until the next latch.
- Latency:
  - Request seen in IDLE at cycle t gives ISSUE at t+1.
  - A cache hit returns output valid at t+2, so resp_valid = 1 at t+3.
  - A miss adds the cache's refill/write-back cycles.
  - Minimum back-to-back spacing: 4 cycles per transaction.
- Simultaneous events:
  - The losing port keeps req high. It is granted in the next IDLE, which is guaranteed under round-robin.
  - The port just served may re-request in the cycle after RESP. It still loses a tie under round-robin.
- Protocol violations:
  - A requester dropping req mid-transaction does not abort. The latched transaction completes and its resp_valid still pulses.
  - Changes to p*_addr/p*_din after the latch are ignored.
- Watchdog:
  - The wait counter counts cycles spent in ISSUE+WAIT and clears on entering RESP.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set to 1 and stays set until reset. The FSM keeps waiting.
- Counters are 32-bit and wrap modulo 2^32.
- Reset mid-transaction: the outstanding transaction is dropped with no resp_valid. Requesters must re-issue after reset.

Test Plan:
- Single read hit: cache preloaded, p0_req at t with addr 0x40 → c_is_input_valid=1 at t+1, p0_resp_valid=1 only at t+3 with p0_dout = cache word, p0_hit=1, p0_served=1, p0_hits=1.
- Tie, round-robin: p0_req and p1_req both high from reset, each held until its own resp_valid → grant order p0, p1. Both re-request immediately → order continues p0, p1, p0; p0_served=2, p1_served=2 after 4 responses.
- Tie, FIXED_PRIORITY=1: both held high for 3 transactions → p1 served all 3, p0_served=0.
- Write miss with dirty eviction: p1 writes 0xDEADBEEF to an address mapping to a set with all 4 ways dirty → c_addr/c_din held stable through write-back and refill, p1_resp_valid once, p1_hit=0. A following p1 read of the same address returns 0xDEADBEEF with hit=1.
- Stall and watchdog (TIMEOUT_CYCLES=8): force c_is_ready=0 → FSM stays in ISSUE, timeout_err=1 after 8 cycles and stays 1 after the cache recovers. Assert reset mid-WAIT → next cycle all outputs and counters 0, no resp_valid issued.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-port arbiter in front of a single-outstanding blocking cache: instruction fetch on
// port 0, data memory on port 1. Also keeps per-port service/hit counters and a hang watchdog.
module cache_port_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic        p0_rw,
    input  logic [31:0] p0_din,
    output logic        p0_resp_valid,
    output logic [31:0] p0_dout,
    output logic        p0_hit,

    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic        p1_rw,
    input  logic [31:0] p1_din,
    output logic        p1_resp_valid,
    output logic [31:0] p1_dout,
    output logic        p1_hit,

    output logic        c_is_input_valid,
    output logic [31:0] c_addr,
    output logic        c_mem_rw,
    output logic [31:0] c_din,
    input  logic        c_is_ready,
    input  logic        c_is_output_valid,
    input  logic [31:0] c_dout,
    input  logic        c_is_hit,

    output logic [31:0] p0_served,
    output logic [31:0] p1_served,
    output logic [31:0] p0_hits,
    output logic [31:0] p1_hits,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [31:0] din_q, din_d;
    logic [31:0] rdata_q, rdata_d;
    logic        hit_q, hit_d;
    logic [31:0] p0_served_q, p0_served_d;
    logic [31:0] p1_served_q, p1_served_d;
    logic [31:0] p0_hits_q, p0_hits_d;
    logic [31:0] p1_hits_q, p1_hits_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] wait_cnt_inc;
    logic        timeout_q, timeout_d;
    logic        grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            din_q        <= '0;
            rdata_q      <= '0;
            hit_q        <= 1'b0;
            p0_served_q  <= '0;
            p1_served_q  <= '0;
            p0_hits_q    <= '0;
            p1_hits_q    <= '0;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            rw_q         <= rw_d;
            din_q        <= din_d;
            rdata_q      <= rdata_d;
            hit_q        <= hit_d;
            p0_served_q  <= p0_served_d;
            p1_served_q  <= p1_served_d;
            p0_hits_q    <= p0_hits_d;
            p1_hits_q    <= p1_hits_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        rw_d         = rw_q;
        din_d        = din_q;
        rdata_d      = rdata_q;
        hit_d        = hit_q;
        p0_served_d  = p0_served_q;
        p1_served_d  = p1_served_q;
        p0_hits_d    = p0_hits_q;
        p1_hits_d    = p1_hits_q;
        wait_cnt_d   = wait_cnt_q;
        wait_cnt_inc = wait_cnt_q;
        timeout_d    = timeout_q;
        grant        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (p0_req || p1_req) begin
                    if (p0_req && p1_req) begin
                        grant = (FIXED_PRIORITY != 0) ? 1'b1 : ~last_grant_q;
                    end else begin
                        grant = p1_req;
                    end
                    owner_d      = grant;
                    last_grant_d = grant;
                    addr_d       = grant ? p1_addr : p0_addr;
                    rw_d         = grant ? p1_rw : p0_rw;
                    din_d        = grant ? p1_din : p0_din;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (c_is_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (c_is_output_valid) begin
                    rdata_d = c_dout;
                    hit_d   = c_is_hit;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_q) begin
                    p1_served_d = p1_served_q + 32'd1;
                    if (hit_q) p1_hits_d = p1_hits_q + 32'd1;
                end else begin
                    p0_served_d = p0_served_q + 32'd1;
                    if (hit_q) p0_hits_d = p0_hits_q + 32'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Saturating count of cycles spent waiting on the cache; the flag never clears here.
        if (state_q == StIssue || state_q == StWait) begin
            if (wait_cnt_q < TIMEOUT_CYCLES) wait_cnt_inc = wait_cnt_q + 32'd1;
            if (wait_cnt_inc >= TIMEOUT_CYCLES) timeout_d = 1'b1;
            wait_cnt_d = (state_d == StResp) ? 32'd0 : wait_cnt_inc;
        end
    end

    assign c_is_input_valid = (state_q == StIssue);
    assign c_addr           = addr_q;
    assign c_mem_rw         = rw_q;
    assign c_din            = din_q;

    assign p0_resp_valid = (state_q == StResp) && !owner_q;
    assign p1_resp_valid = (state_q == StResp) && owner_q;
    assign p0_dout       = rdata_q;
    assign p1_dout       = rdata_q;
    assign p0_hit        = hit_q;
    assign p1_hit        = hit_q;

    assign p0_served   = p0_served_q;
    assign p1_served   = p1_served_q;
    assign p0_hits     = p0_hits_q;
    assign p1_hits     = p1_hits_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: the initial block plays both requesters and the cache
// cycle by cycle against a round-robin instance and a fixed-priority instance.
module tb_cache_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        p0_req = 0, p0_rw = 0, p1_req = 0, p1_rw = 0;
    logic [31:0] p0_addr = 0, p0_din = 0, p1_addr = 0, p1_din = 0;
    logic        c_is_ready = 1, c_is_output_valid = 0, c_is_hit = 0;
    logic [31:0] c_dout = 0;
    logic        sel = 0;

    logic        rr_p0_rv, rr_p0_hit, rr_p1_rv, rr_p1_hit, rr_iv, rr_rw, rr_to;
    logic [31:0] rr_p0_dout, rr_p1_dout, rr_addr, rr_din;
    logic [31:0] rr_p0_srv, rr_p1_srv, rr_p0_hits, rr_p1_hits;
    logic        fp_p0_rv, fp_p0_hit, fp_p1_rv, fp_p1_hit, fp_iv, fp_rw, fp_to;
    logic [31:0] fp_p0_dout, fp_p1_dout, fp_addr, fp_din;
    logic [31:0] fp_p0_srv, fp_p1_srv, fp_p0_hits, fp_p1_hits;

    cache_port_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut_rr (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rw(p0_rw), .p0_din(p0_din),
        .p0_resp_valid(rr_p0_rv), .p0_dout(rr_p0_dout), .p0_hit(rr_p0_hit),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_rw(p1_rw), .p1_din(p1_din),
        .p1_resp_valid(rr_p1_rv), .p1_dout(rr_p1_dout), .p1_hit(rr_p1_hit),
        .c_is_input_valid(rr_iv), .c_addr(rr_addr), .c_mem_rw(rr_rw), .c_din(rr_din),
        .c_is_ready(c_is_ready), .c_is_output_valid(c_is_output_valid), .c_dout(c_dout),
        .c_is_hit(c_is_hit),
        .p0_served(rr_p0_srv), .p1_served(rr_p1_srv), .p0_hits(rr_p0_hits),
        .p1_hits(rr_p1_hits), .timeout_err(rr_to)
    );

    cache_port_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_rw(p0_rw), .p0_din(p0_din),
        .p0_resp_valid(fp_p0_rv), .p0_dout(fp_p0_dout), .p0_hit(fp_p0_hit),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_rw(p1_rw), .p1_din(p1_din),
        .p1_resp_valid(fp_p1_rv), .p1_dout(fp_p1_dout), .p1_hit(fp_p1_hit),
        .c_is_input_valid(fp_iv), .c_addr(fp_addr), .c_mem_rw(fp_rw), .c_din(fp_din),
        .c_is_ready(c_is_ready), .c_is_output_valid(c_is_output_valid), .c_dout(c_dout),
        .c_is_hit(c_is_hit),
        .p0_served(fp_p0_srv), .p1_served(fp_p1_srv), .p0_hits(fp_p0_hits),
        .p1_hits(fp_p1_hits), .timeout_err(fp_to)
    );

    // Observed view of whichever instance is under test (both see the same stimulus).
    wire        o_p0_rv   = sel ? fp_p0_rv   : rr_p0_rv;
    wire        o_p1_rv   = sel ? fp_p1_rv   : rr_p1_rv;
    wire        o_p0_hit  = sel ? fp_p0_hit  : rr_p0_hit;
    wire        o_p1_hit  = sel ? fp_p1_hit  : rr_p1_hit;
    wire [31:0] o_p0_dout = sel ? fp_p0_dout : rr_p0_dout;
    wire [31:0] o_p1_dout = sel ? fp_p1_dout : rr_p1_dout;
    wire        o_iv      = sel ? fp_iv      : rr_iv;
    wire        o_rw      = sel ? fp_rw      : rr_rw;
    wire [31:0] o_addr    = sel ? fp_addr    : rr_addr;
    wire [31:0] o_din     = sel ? fp_din     : rr_din;
    wire [31:0] o_p0_srv  = sel ? fp_p0_srv  : rr_p0_srv;
    wire [31:0] o_p1_srv  = sel ? fp_p1_srv  : rr_p1_srv;
    wire [31:0] o_p0_hits = sel ? fp_p0_hits : rr_p0_hits;
    wire [31:0] o_p1_hits = sel ? fp_p1_hits : rr_p1_hits;
    wire        o_to      = sel ? fp_to      : rr_to;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_iv", o_iv, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_rw", o_rw, 0);
        chk("rst_din", o_din, 0);
        chk("rst_rv", {o_p0_rv, o_p1_rv}, 0);
        chk("rst_dout", o_p0_dout | o_p1_dout, 0);
        chk("rst_hit", {o_p0_hit, o_p1_hit}, 0);
        chk("rst_cnt", o_p0_srv | o_p1_srv | o_p0_hits | o_p1_hits, 0);
        chk("rst_to", o_to, 0);
        reset = 1'b0;
    endtask

    // Called in an IDLE cycle with requests already applied; returns in the following IDLE cycle.
    task automatic run_xact(input logic port, input logic [31:0] addr, input logic rw,
                            input logic [31:0] din, input logic [31:0] rdata, input logic hit,
                            input int miss, input logic drop);
        tick();
        chk("issue_iv", o_iv, 1);
        chk("issue_addr", o_addr, addr);
        chk("issue_rw", o_rw, rw);
        chk("issue_din", o_din, din);
        chk("issue_norv", {o_p0_rv, o_p1_rv}, 0);
        if (drop) begin
            p0_req = 0;
            p1_req = 0;
            p0_addr = 32'hFFFF_FFFC;
            p1_addr = 32'hFFFF_FFFC;
            p0_din = 32'h5555_5555;
            p1_din = 32'h5555_5555;
        end
        tick();
        for (int i = 0; i < miss; i++) begin
            chk("wait_iv", o_iv, 0);
            chk("wait_addr", o_addr, addr);
            chk("wait_din", o_din, din);
            tick();
        end
        c_is_output_valid = 1;
        c_dout = rdata;
        c_is_hit = hit;
        chk("wait_norv", {o_p0_rv, o_p1_rv}, 0);
        chk("wait_addr_last", o_addr, addr);
        tick();
        c_is_output_valid = 0;
        c_dout = 0;
        c_is_hit = 0;
        chk("resp_p0_rv", o_p0_rv, !port);
        chk("resp_p1_rv", o_p1_rv, port);
        chk("resp_dout", port ? o_p1_dout : o_p0_dout, rdata);
        chk("resp_hit", port ? o_p1_hit : o_p0_hit, hit);
        tick();
        chk("idle_norv", {o_p0_rv, o_p1_rv}, 0);
    endtask

    initial begin
        // Single read hit with a requester that drops req and scrambles addr after the latch.
        sel = 0;
        do_reset();
        p0_req = 1;
        p0_addr = 32'h40;
        run_xact(0, 32'h40, 0, 0, 32'h1234_5678, 1, 0, 1);
        chk("hit_p0_served", o_p0_srv, 1);
        chk("hit_p0_hits", o_p0_hits, 1);
        chk("hit_p1_served", o_p1_srv, 0);

        // Round-robin tie from reset, both re-requesting immediately.
        do_reset();
        p0_req = 1; p0_addr = 32'h100; p0_din = 32'h0;
        p1_req = 1; p1_addr = 32'h200; p1_din = 32'h0;
        run_xact(0, 32'h100, 0, 0, 32'hA000_0001, 1, 0, 0);
        run_xact(1, 32'h200, 0, 0, 32'hB000_0001, 1, 0, 0);
        run_xact(0, 32'h100, 0, 0, 32'hA000_0002, 1, 0, 0);
        run_xact(1, 32'h200, 0, 0, 32'hB000_0002, 0, 0, 0);
        p0_req = 0;
        p1_req = 0;
        chk("rr_p0_served", o_p0_srv, 2);
        chk("rr_p1_served", o_p1_srv, 2);
        chk("rr_p0_hits", o_p0_hits, 2);
        chk("rr_p1_hits", o_p1_hits, 1);

        // Write miss with a long refill, then read-back hit; lone requester wins despite last_grant.
        p1_req = 1; p1_addr = 32'h1000; p1_rw = 1; p1_din = 32'hDEAD_BEEF;
        run_xact(1, 32'h1000, 1, 32'hDEAD_BEEF, 32'h0, 0, 3, 0);
        p1_rw = 0; p1_din = 32'h0;
        run_xact(1, 32'h1000, 0, 32'h0, 32'hDEAD_BEEF, 1, 0, 0);
        p1_req = 0;
        chk("wm_p1_served", o_p1_srv, 4);
        chk("wm_p1_hits", o_p1_hits, 2);
        chk("wm_p0_served", o_p0_srv, 2);
        chk("wm_to", o_to, 0);

        // Fixed priority: port 1 wins every tie.
        sel = 1;
        do_reset();
        p0_req = 1; p0_addr = 32'h100; p0_rw = 0; p0_din = 0;
        p1_req = 1; p1_addr = 32'h200; p1_rw = 0; p1_din = 0;
        run_xact(1, 32'h200, 0, 0, 32'hC000_0001, 1, 0, 0);
        run_xact(1, 32'h200, 0, 0, 32'hC000_0002, 0, 0, 0);
        run_xact(1, 32'h200, 0, 0, 32'hC000_0003, 1, 0, 0);
        p0_req = 0;
        p1_req = 0;
        chk("fp_p1_served", o_p1_srv, 3);
        chk("fp_p0_served", o_p0_srv, 0);
        chk("fp_p1_hits", o_p1_hits, 2);

        // Stalled cache trips the watchdog; reset mid-WAIT drops the transaction.
        sel = 0;
        do_reset();
        c_is_ready = 0;
        p0_req = 1; p0_addr = 32'h80;
        tick();
        chk("stall_iv0", o_iv, 1);
        repeat (6) tick();
        chk("stall_iv6", o_iv, 1);
        chk("stall_to6", o_to, 0);
        repeat (2) tick();
        chk("stall_iv8", o_iv, 1);
        chk("stall_to8", o_to, 1);
        c_is_ready = 1;
        tick();
        chk("recov_iv", o_iv, 0);
        chk("recov_addr", o_addr, 32'h80);
        chk("recov_to", o_to, 1);
        reset = 1;
        p0_req = 0;
        tick();
        chk("mid_rst_iv", o_iv, 0);
        chk("mid_rst_addr", o_addr, 0);
        chk("mid_rst_rv", {o_p0_rv, o_p1_rv}, 0);
        chk("mid_rst_cnt", o_p0_srv | o_p1_srv | o_p0_hits | o_p1_hits, 0);
        chk("mid_rst_to", o_to, 0);
        reset = 0;
        c_is_output_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_norv", {o_p0_rv, o_p1_rv}, 0);
        end
        c_is_output_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
